data_mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of data_memory. Port 0 = core load/store unit, port 1 = debug/DMA.

---
 rtl/data_mem_arbiter.sv | 125 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of data_memory: serialises port 0 (LSU) and port 1 (debug/DMA)
// requests, drives the memory strobes and returns a one-cycle ack plus registered read data.
module data_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIXED_PRIO   = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} stateT;

    localparam logic [1:0] LAST_WAIT = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    stateT                 state;
    logic                  winner;
    logic                  latchWe;
    logic                  rrPtr;
    logic [1:0]            waitCnt;
    logic                  grant1;
    logic                  selWe;
    logic [ADDR_WIDTH-1:0] selAddr;
    logic [DATA_WIDTH-1:0] selWdata;

    // Port 1 wins when alone, or on a tie when round-robin points at it.
    always_comb begin
        grant1   = req1 && (!req0 || ((FIXED_PRIO == 0) && rrPtr));
        selWe    = grant1 ? we1 : we0;
        selAddr  = grant1 ? addr1 : addr0;
        selWdata = grant1 ? wdata1 : wdata0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            winner         <= 1'b0;
            latchWe        <= 1'b0;
            rrPtr          <= 1'b0;
            waitCnt        <= '0;
            ack0           <= 1'b0;
            ack1           <= 1'b0;
            rdata0         <= '0;
            rdata1         <= '0;
            busy           <= 1'b0;
            mem_address    <= '0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_write_data <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state          <= ACCESS;
                        busy           <= 1'b1;
                        winner         <= grant1;
                        latchWe        <= selWe;
                        mem_address    <= selAddr;
                        mem_write_data <= selWdata;
                        mem_write      <= selWe;
                        mem_read       <= !selWe;
                        waitCnt        <= '0;
                    end
                end
                ACCESS: begin
                    if (latchWe) begin
                        mem_write <= 1'b0;
                        ack0      <= !winner;
                        ack1      <= winner;
                        state     <= DONE;
                    end else if (READ_LATENCY == 0) begin
                        if (winner) rdata1 <= mem_read_data;
                        else        rdata0 <= mem_read_data;
                        mem_read <= 1'b0;
                        ack0     <= !winner;
                        ack1     <= winner;
                        state    <= DONE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (waitCnt == LAST_WAIT) begin
                        if (winner) rdata1 <= mem_read_data;
                        else        rdata0 <= mem_read_data;
                        mem_read <= 1'b0;
                        ack0     <= !winner;
                        ack1     <= winner;
                        state    <= DONE;
                    end else begin
                        waitCnt <= waitCnt + 2'd1;
                    end
                end
                DONE: begin
                    rrPtr <= !winner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: four instances (RL1 round-robin, RL1 fixed priority, RL0, RL3)
// each with a behavioural data_memory whose read data appears READ_LATENCY cycles after the address.
module tb_data_mem_arbiter;

    localparam int NI = 4;
    localparam int RLS [NI] = '{1, 1, 0, 3};
    localparam int FPS [NI] = '{0, 1, 0, 0};

    typedef struct {
        int          inst;
        int          port;
        logic        isRead;
        logic [31:0] data;
    } expT;

    logic        clock;
    logic        rstN;
    logic        req0 [NI];
    logic        req1 [NI];
    logic        we0 [NI];
    logic        we1 [NI];
    logic [6:0]  addr0 [NI];
    logic [6:0]  addr1 [NI];
    logic [31:0] wdata0 [NI];
    logic [31:0] wdata1 [NI];
    logic        ack0 [NI];
    logic        ack1 [NI];
    logic [31:0] rdata0 [NI];
    logic [31:0] rdata1 [NI];
    logic        busy [NI];
    logic [6:0]  memAddress [NI];
    logic        memWrite [NI];
    logic        memRead [NI];
    logic [31:0] memWriteData [NI];
    logic [31:0] memReadData [NI];

    expT         sbQ [$];
    logic [31:0] shadow [NI][2];
    bit          holdReq [NI];
    int          ack1Count [NI];
    int          nTests = 0;
    int          nFail = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar k = 0; k < NI; k++) begin : g
        logic [31:0] mem [128];
        logic [31:0] pipe [3];

        data_mem_arbiter #(
            .ADDR_WIDTH(7),
            .DATA_WIDTH(32),
            .READ_LATENCY(RLS[k]),
            .FIXED_PRIO(FPS[k])
        ) dut (
            .clock(clock),
            .reset_n(rstN),
            .req0(req0[k]),
            .req1(req1[k]),
            .we0(we0[k]),
            .we1(we1[k]),
            .addr0(addr0[k]),
            .addr1(addr1[k]),
            .wdata0(wdata0[k]),
            .wdata1(wdata1[k]),
            .ack0(ack0[k]),
            .ack1(ack1[k]),
            .rdata0(rdata0[k]),
            .rdata1(rdata1[k]),
            .busy(busy[k]),
            .mem_address(memAddress[k]),
            .mem_write(memWrite[k]),
            .mem_read(memRead[k]),
            .mem_write_data(memWriteData[k]),
            .mem_read_data(memReadData[k])
        );

        initial begin
            for (int i = 0; i < 128; i++) mem[i] = '0;
            for (int i = 0; i < 3; i++) pipe[i] = '0;
        end

        always @(posedge clock) begin
            if (memWrite[k]) mem[memAddress[k]] <= memWriteData[k];
            pipe[0] <= mem[memAddress[k]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end

        if (RLS[k] == 0) begin : comb
            assign memReadData[k] = mem[memAddress[k]];
        end else begin : piped
            assign memReadData[k] = pipe[RLS[k] - 1];
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clearShadow();
        for (int k = 0; k < NI; k++) begin
            shadow[k][0] = '0;
            shadow[k][1] = '0;
        end
    endtask

    task automatic issue(input int k, input int p, input logic w, input logic [6:0] a,
                         input logic [31:0] d, input logic [31:0] ed);
        if (p == 0) begin
            we0[k] = w; addr0[k] = a; wdata0[k] = d; req0[k] = 1'b1;
        end else begin
            we1[k] = w; addr1[k] = a; wdata1[k] = d; req1[k] = 1'b1;
        end
        sbQ.push_back('{k, p, !w, ed});
    endtask

    // Pops the scoreboard on every ack and releases the acked request on that same negedge.
    task automatic monitor();
        expT e;
        logic a;
        forever begin
            @(negedge clock);
            for (int k = 0; k < NI; k++) begin
                checkEq("noRdWrOverlap", {31'b0, memRead[k] & memWrite[k]}, 0);
                checkEq("singleAck", {31'b0, ack0[k] & ack1[k]}, 0);
                for (int p = 0; p < 2; p++) begin
                    a = (p == 1) ? ack1[k] : ack0[k];
                    if (a) begin
                        if (p == 1) ack1Count[k]++;
                        if (sbQ.size() == 0) begin
                            checkEq("unexpectedAck", 1, 0);
                        end else begin
                            e = sbQ.pop_front();
                            checkEq("ackInst", k, e.inst);
                            checkEq("ackPort", p, e.port);
                            if (e.isRead) shadow[k][p] = e.data;
                        end
                        if (!holdReq[k]) begin
                            if (p == 0) req0[k] = 1'b0;
                            else        req1[k] = 1'b0;
                        end
                        if (sbQ.size() == 0) begin
                            req0[k] = 1'b0;
                            req1[k] = 1'b0;
                        end
                    end
                end
                checkEq("rdata0", rdata0[k], shadow[k][0]);
                checkEq("rdata1", rdata1[k], shadow[k][1]);
            end
        end
    endtask

    task automatic waitIdle(input int k, input int maxCycles);
        bit done = 0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            @(negedge clock);
            if (sbQ.size() == 0 && !busy[k]) done = 1;
        end
        if (!done) checkEq("waitIdleTimeout", 0, 1);
    endtask

    // Latency counted in cycles after the IDLE cycle that sees the request (ACCESS = cycle 1).
    task automatic measureOp(input int k, input int p, input logic w, input logic [6:0] a,
                             input logic [31:0] d, input logic [31:0] ed, input int expLat,
                             input int expStrobe, input string tag);
        int  n = 0;
        int  strobes = 0;
        bit  seen = 0;
        issue(k, p, w, a, d, ed);
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clock);
            if (w ? memWrite[k] : memRead[k]) begin
                strobes++;
                checkEq({tag, "Addr"}, {25'b0, memAddress[k]}, {25'b0, a});
                if (w) checkEq({tag, "WData"}, memWriteData[k], d);
            end
            if ((p == 1) ? ack1[k] : ack0[k]) begin
                seen = 1;
                n = i;
            end
        end
        checkEq({tag, "Latency"}, n, expLat);
        checkEq({tag, "StrobeCycles"}, strobes, expStrobe);
        @(negedge clock);
        checkEq({tag, "BusyIdle"}, {31'b0, busy[k]}, 0);
    endtask

    initial begin
        rstN = 1'b0;
        for (int k = 0; k < NI; k++) begin
            req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
            addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
            holdReq[k] = 0; ack1Count[k] = 0;
        end
        clearShadow();
        repeat (2) @(negedge clock);
        for (int unsigned k = 0; k < NI; k++) begin
            checkEq("rstAck", {30'b0, ack1[k], ack0[k]}, 0);
            checkEq("rstBusy", {31'b0, busy[k]}, 0);
            checkEq("rstStrobes", {30'b0, memWrite[k], memRead[k]}, 0);
            checkEq("rstAddr", {25'b0, memAddress[k]}, 0);
            checkEq("rstWData", memWriteData[k], 0);
            checkEq("rstRdata0", rdata0[k], 0);
            checkEq("rstRdata1", rdata1[k], 0);
        end
        rstN = 1'b1;
        fork
            monitor();
        join_none

        // Async reset in the middle of a read's WAIT cycle abandons it without an ack.
        @(negedge clock);
        issue(0, 0, 1'b0, 7'd1, 32'd0, 32'd0);
        @(negedge clock);
        @(posedge clock);
        #2;
        checkEq("midWaitRead", {31'b0, memRead[0]}, 1);
        checkEq("midWaitBusy", {31'b0, busy[0]}, 1);
        rstN = 1'b0;
        #1;
        checkEq("asyncRstRead", {31'b0, memRead[0]}, 0);
        checkEq("asyncRstWrite", {31'b0, memWrite[0]}, 0);
        checkEq("asyncRstBusy", {31'b0, busy[0]}, 0);
        checkEq("asyncRstAck", {30'b0, ack1[0], ack0[0]}, 0);
        checkEq("asyncRstRdata0", rdata0[0], 0);
        sbQ.delete();
        req0[0] = 1'b0;
        @(negedge clock);
        rstN = 1'b1;
        repeat (4) begin
            @(negedge clock);
            checkEq("postRstIdle", {31'b0, busy[0]}, 0);
        end

        // Port 0 write then read-back.
        measureOp(0, 0, 1'b1, 7'd1, 32'd42, 32'd0, 2, 1, "p0Write");
        measureOp(0, 0, 1'b0, 7'd1, 32'd0, 32'd42, 3, 2, "p0Read");

        // Tie from reset: port 0 first, then round-robin alternation.
        @(negedge clock);
        rstN = 1'b0;
        clearShadow();
        issue(0, 0, 1'b0, 7'd2, 32'd0, 32'd0);
        issue(0, 1, 1'b1, 7'd2, 32'd99, 32'd0);
        @(negedge clock);
        rstN = 1'b1;
        waitIdle(0, 30);
        issue(0, 1, 1'b0, 7'd2, 32'd0, 32'd99);
        waitIdle(0, 20);
        issue(0, 0, 1'b0, 7'd1, 32'd0, 32'd42);
        issue(0, 1, 1'b0, 7'd2, 32'd0, 32'd99);
        waitIdle(0, 30);
        issue(0, 0, 1'b1, 7'd4, 32'd7, 32'd0);
        waitIdle(0, 20);
        issue(0, 1, 1'b0, 7'd1, 32'd0, 32'd42);
        issue(0, 0, 1'b0, 7'd4, 32'd0, 32'd7);
        waitIdle(0, 30);

        // Port 1 drops req during WAIT: its ack still arrives once, then the arbiter idles.
        issue(0, 1, 1'b0, 7'd2, 32'd0, 32'd99);
        @(negedge clock);
        @(negedge clock);
        req1[0] = 1'b0;
        waitIdle(0, 20);
        repeat (3) begin
            @(negedge clock);
            checkEq("idleAfterDrop", {31'b0, busy[0]}, 0);
        end

        // Fixed priority: port 1 starves while port 0 holds its request.
        holdReq[1] = 1;
        we1[1] = 1'b1; addr1[1] = 7'd6; wdata1[1] = 32'd77; req1[1] = 1'b1;
        for (int i = 0; i < 5; i++) issue(1, 0, 1'b0, 7'd5, 32'd0, 32'd0);
        waitIdle(1, 60);
        holdReq[1] = 0;
        checkEq("fixedPrioAck1Count", ack1Count[1], 0);
        issue(1, 1, 1'b0, 7'd6, 32'd0, 32'd0);
        waitIdle(1, 20);

        // Latency extremes.
        measureOp(2, 0, 1'b1, 7'd3, 32'd55, 32'd0, 2, 1, "rl0Write");
        measureOp(2, 1, 1'b0, 7'd3, 32'd0, 32'd55, 2, 1, "rl0Read");
        measureOp(3, 1, 1'b1, 7'd9, 32'd123, 32'd0, 2, 1, "rl3Write");
        measureOp(3, 0, 1'b0, 7'd9, 32'd0, 32'd123, 5, 4, "rl3Read");

        checkEq("scoreboardEmpty", sbQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
